// File: rtl/regbank_arb_pkg.sv
// regbank_arb_pkg
// Shared definitions for the register-bank write arbiter: the sequencer state
// encoding, default address/data widths and a helper that returns the number
// of registers addressed by an AW-bit address.
package regbank_arb_pkg;

  // Sequencer states: normal arbitration, clear sweep, one-cycle completion.
  typedef enum logic [1:0] {
    ARB   = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } arb_state_e;

  localparam int AW_DEF = 3;
  localparam int DW_DEF = 8;

  // Number of registers reachable with an aw-bit address.
  function automatic int nregs(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin pick. The search starts one above the
// pointer and wraps, so the requester granted last has lowest priority.
// Ports:
//   valid_i     in  N_REQ  request vector
//   rr_ptr_i    in  PTR_W  index of the most recently served requester
//   grant_o     out N_REQ  one-hot grant (zero when nothing is valid)
//   winner_o    out PTR_W  index of the granted requester
//   any_valid_o out 1      at least one requester is valid
module rr_arbiter
  import regbank_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int PTR_W = 1
) (
  input  logic [N_REQ-1:0] valid_i,
  input  logic [PTR_W-1:0] rr_ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [PTR_W-1:0] winner_o,
  output logic             any_valid_o
);

  logic [PTR_W-1:0] idx;
  logic             found;

  // Walk the requesters in priority order; the first valid one wins and
  // later candidates are masked off by 'found'.
  always_comb begin
    grant_o  = '0;
    winner_o = '0;
    idx      = '0;
    found    = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = PTR_W'((int'(rr_ptr_i) + k) % N_REQ);
      if (!found && valid_i[idx]) begin
        grant_o[idx] = 1'b1;
        winner_o     = idx;
        found        = 1'b1;
      end
    end
    any_valid_o = found;
  end

endmodule

// File: rtl/regbank_write_arbiter.sv
// regbank_write_arbiter
// Shares the single write port (we3/wa3/wd3) of the register bank among
// N_REQ requesters with round-robin arbitration and a valid/ready handshake.
// A clear sequencer writes zero to registers 1..2**AW-1 on command. Writes
// to address 0 are accepted but never reach the bank, because the bank
// aliases address 0 onto register 1.
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready per-requester handshake (ready is combinational)
//   req_addr/req_data   packed per-requester address/data slices
//   clr_start           request a clear sweep
//   clr_busy/clr_done   sweep in progress / one-cycle completion pulse
//   x0_drop             one-cycle pulse: an accepted write to address 0 dropped
//   we3/wa3/wd3         registered bank write port
//   grant_cnt           per-requester saturating grant counters, present only
//                       when REGARB_STATS_EN is defined
module regbank_write_arbiter
  import regbank_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_data,
  input  logic               clr_start,
  output logic               clr_busy,
  output logic               clr_done,
  output logic               x0_drop,
  output logic               we3,
  output logic [AW-1:0]      wa3,
  output logic [DW-1:0]      wd3
`ifdef REGARB_STATS_EN
  ,
  output logic [N_REQ*CNT_W-1:0] grant_cnt
`endif
);

  localparam int              PTR_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [AW-1:0]   LAST_ADDR = AW'(nregs(AW) - 1);
  localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(N_REQ - 1);

  arb_state_e       state_q, state_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             we3_q, we3_d;
  logic [AW-1:0]    wa3_q, wa3_d;
  logic [DW-1:0]    wd3_q, wd3_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             x0_q, x0_d;

  logic [N_REQ-1:0] grant;
  logic [PTR_W-1:0] winner;
  logic             any_valid;
  logic             arb_open;
  logic             transfer;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_data;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .valid_i     (req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (grant),
    .winner_o    (winner),
    .any_valid_o (any_valid)
  );

  // Requesters are only served in ARB, and a pending clear request takes
  // precedence over every requester in the same cycle.
  assign arb_open  = (state_q == ARB) && !clr_start;
  assign req_ready = arb_open ? grant : '0;
  assign transfer  = arb_open && any_valid;

  // Mux out the winning requester's address and data slices.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  // Next-state logic. Every port-facing output is registered, so the status
  // flags line up with the write they describe: clr_busy is high exactly
  // while the sweep writes are on the port, and clr_done follows the last.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    we3_d    = 1'b0;
    wa3_d    = wa3_q;
    wd3_d    = wd3_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    x0_d     = 1'b0;
    case (state_q)
      ARB: begin
        if (clr_start) begin
          state_d = CLEAR;
        end else if (transfer) begin
          rr_ptr_d = winner;
          if (sel_addr != '0) begin
            we3_d = 1'b1;
            wa3_d = sel_addr;
            wd3_d = sel_data;
          end else begin
            x0_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        we3_d  = 1'b1;
        wa3_d  = cnt_q;
        wd3_d  = '0;
        busy_d = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        cnt_d   = AW'(1);
        state_d = ARB;
      end
      default: begin
        state_d = ARB;
      end
    endcase
  end

  // State and output registers; reset abandons any sweep in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB;
      rr_ptr_q <= PTR_INIT;
      cnt_q    <= AW'(1);
      we3_q    <= 1'b0;
      wa3_q    <= '0;
      wd3_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      x0_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      we3_q    <= we3_d;
      wa3_q    <= wa3_d;
      wd3_q    <= wd3_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      x0_q     <= x0_d;
    end
  end

  assign we3      = we3_q;
  assign wa3      = wa3_q;
  assign wd3      = wd3_q;
  assign clr_busy = busy_q;
  assign clr_done = done_q;
  assign x0_drop  = x0_q;

`ifdef REGARB_STATS_EN
  // One saturating counter per requester; counts every completed handshake,
  // including dropped address-0 writes, and is untouched by clear sweeps.
  for (genvar g = 0; g < N_REQ; g++) begin : g_stats
    logic [CNT_W-1:0] gcnt_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        gcnt_q <= '0;
      end else if (transfer && grant[g] && (gcnt_q != '1)) begin
        gcnt_q <= gcnt_q + 1'b1;
      end
    end

    assign grant_cnt[g*CNT_W +: CNT_W] = gcnt_q;
  end
`endif

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// tb_regbank_write_arbiter
// Scoreboard bench for regbank_write_arbiter (N_REQ=2, AW=3, DW=8, CNT_W=2).
// A behavioural model predicts req_ready and the registered port values; the
// predictions are queued when stimulus is driven and popped after the edge.
module tb_regbank_write_arbiter;

  typedef struct packed {
    logic       we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic       x0;
    logic       busy;
    logic       done;
  } port_t;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [5:0]  req_addr;
  logic [15:0] req_data;
  logic        clr_start;
  logic        clr_busy;
  logic        clr_done;
  logic        x0_drop;
  logic        we3;
  logic [2:0]  wa3;
  logic [7:0]  wd3;
`ifdef REGARB_STATS_EN
  logic [3:0]  grant_cnt;
`endif

  int          compared;
  int          mismatched;
  port_t       expQ[$];

  int          mState;
  int          mPtr;
  logic [2:0]  mCnt;
  logic [2:0]  mWa;
  logic [7:0]  mWd;
  logic [1:0]  sampledReady;
  logic [7:0]  bank [8];

  regbank_write_arbiter #(
    .N_REQ (2),
    .AW    (3),
    .DW    (8),
    .CNT_W (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .x0_drop   (x0_drop),
    .we3       (we3),
    .wa3       (wa3),
    .wd3       (wd3)
`ifdef REGARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Minimal model of the register bank behind the port, including the
  // hardware alias of address 0 onto register 1.
  always @(posedge clk) begin
    if (!rst && we3) begin
      if (wa3 == 3'd0) bank[1] <= wd3;
      else             bank[wa3] <= wd3;
    end
  end

  // Counts one comparison and reports it when the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one cycle of stimulus, predicts ready and the next registered
  // port values, then checks both around the following rising edge.
  task automatic applyStimulus(input logic [1:0] v, input logic [2:0] a0,
                               input logic [7:0] d0, input logic [2:0] a1,
                               input logic [7:0] d1, input logic cs,
                               input string tag);
    logic [1:0] expReady;
    port_t      nxt;
    port_t      exp;
    int         w;
    int         idx;
    logic [2:0] addr;
    logic [7:0] data;
    req_valid = v;
    req_addr  = {a1, a0};
    req_data  = {d1, d0};
    clr_start = cs;
    expReady  = 2'b00;
    nxt       = '0;
    nxt.wa    = mWa;
    nxt.wd    = mWd;
    case (mState)
      0: begin
        if (cs) begin
          mState = 1;
        end else begin
          w = -1;
          for (int k = 1; k <= 2; k++) begin
            idx = (mPtr + k) % 2;
            if (w < 0 && v[idx[0]]) w = idx;
          end
          if (w >= 0) begin
            expReady[w[0]] = 1'b1;
            mPtr = w;
            addr = (w == 0) ? a0 : a1;
            data = (w == 0) ? d0 : d1;
            if (addr != 3'd0) begin
              nxt.we = 1'b1;
              nxt.wa = addr;
              nxt.wd = data;
            end else begin
              nxt.x0 = 1'b1;
            end
          end
        end
      end
      1: begin
        nxt.we   = 1'b1;
        nxt.wa   = mCnt;
        nxt.wd   = 8'h00;
        nxt.busy = 1'b1;
        if (mCnt == 3'd7) mState = 2;
        mCnt = mCnt + 3'd1;
      end
      default: begin
        nxt.done = 1'b1;
        mCnt     = 3'd1;
        mState   = 0;
      end
    endcase
    mWa = nxt.wa;
    mWd = nxt.wd;
    expQ.push_back(nxt);
    #1;
    sampledReady = req_ready;
    checkOutput({tag, ":ready"}, req_ready, expReady);
    @(posedge clk);
    #1;
    exp = expQ.pop_front();
    checkOutput({tag, ":we3"}, we3, exp.we);
    checkOutput({tag, ":wa3"}, wa3, exp.wa);
    checkOutput({tag, ":wd3"}, wd3, exp.wd);
    checkOutput({tag, ":x0"}, x0_drop, exp.x0);
    checkOutput({tag, ":busy"}, clr_busy, exp.busy);
    checkOutput({tag, ":done"}, clr_done, exp.done);
  endtask

  // Asserts reset mid-cycle, checks that outputs clear at once, then
  // releases it just after a rising edge and restores the model.
  task automatic doReset(input string tag);
    req_valid = 2'b00;
    clr_start = 1'b0;
    rst       = 1'b1;
    #1;
    checkOutput({tag, ":we3"}, we3, 1'b0);
    checkOutput({tag, ":wa3"}, wa3, 3'd0);
    checkOutput({tag, ":wd3"}, wd3, 8'h00);
    checkOutput({tag, ":busy"}, clr_busy, 1'b0);
    checkOutput({tag, ":done"}, clr_done, 1'b0);
    checkOutput({tag, ":x0"}, x0_drop, 1'b0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mState = 0;
    mPtr   = 1;
    mCnt   = 3'd1;
    mWa    = 3'd0;
    mWd    = 8'h00;
    expQ.delete();
  endtask

  // Main sequence.
  initial begin
    logic [1:0] rrExp [4];
    logic [7:0] reg1Before;
`ifdef REGARB_STATS_EN
    logic [1:0] gExp [5];
`endif
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    req_valid  = 2'b00;
    req_addr   = '0;
    req_data   = '0;
    clr_start  = 1'b0;
    for (int i = 0; i < 8; i++) bank[i] = 8'h00;
    $display("[TB] start");
    @(posedge clk);
    doReset("reset");

    // Single write from requester 0 appears one cycle later.
    applyStimulus(2'b01, 3'd3, 8'hA5, 3'd0, 8'h00, 1'b0, "wr0");
    checkOutput("wr0:direct_wa3", wa3, 3'd3);
    checkOutput("wr0:direct_wd3", wd3, 8'hA5);

    // Seed register 1, then requester 1 writes address 0 which must drop.
    applyStimulus(2'b01, 3'd1, 8'h3C, 3'd0, 8'h00, 1'b0, "seed1");
    applyStimulus(2'b10, 3'd0, 8'h00, 3'd0, 8'hFF, 1'b0, "x0");
    checkOutput("x0:direct_ready", sampledReady, 2'b10);
    checkOutput("x0:direct_pulse", x0_drop, 1'b1);
    applyStimulus(2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 1'b0, "idle0");
    reg1Before = bank[1];
    checkOutput("x0:bank1", reg1Before, 8'h3C);

    // Both requesters held valid: grants must alternate 0,1,0,1.
    rrExp = '{2'b01, 2'b10, 2'b01, 2'b10};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b11, 3'd2, 8'h11 + 8'(i), 3'd4, 8'h22 + 8'(i), 1'b0, "rr");
      checkOutput("rr:order", sampledReady, rrExp[i]);
    end

    // Clear sweep requested alongside a valid requester.
    applyStimulus(2'b01, 3'd6, 8'h77, 3'd0, 8'h00, 1'b1, "clr_req");
    checkOutput("clr_req:blocked", sampledReady, 2'b00);
    for (int k = 1; k <= 7; k++) begin
      applyStimulus(2'b01, 3'd6, 8'h77, 3'd0, 8'h00, (k == 3), "clr");
      checkOutput("clr:addr", wa3, 32'(k));
    end
    applyStimulus(2'b01, 3'd6, 8'h77, 3'd0, 8'h00, 1'b1, "clr_done");
    checkOutput("clr_done:pulse", clr_done, 1'b1);
    applyStimulus(2'b01, 3'd6, 8'h77, 3'd0, 8'h00, 1'b0, "post_clr");
    checkOutput("post_clr:grant", sampledReady, 2'b01);

    // Reset after the third sweep write abandons the sweep.
    applyStimulus(2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 1'b1, "clr2_req");
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 1'b0, "clr2");
    end
    checkOutput("clr2:third", wa3, 3'd3);
    doReset("midclr_rst");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 1'b0, "after_rst");
    end

    // A fresh sweep completes all seven writes.
    applyStimulus(2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 1'b1, "clr3_req");
    for (int k = 1; k <= 7; k++) begin
      applyStimulus(2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 1'b0, "clr3");
    end
    applyStimulus(2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 1'b0, "clr3_done");
    checkOutput("clr3_done:pulse", clr_done, 1'b1);
    applyStimulus(2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 1'b0, "idle1");

`ifdef REGARB_STATS_EN
    // Two-bit grant counter saturates at 3.
    doReset("stats_rst");
    gExp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(2'b01, 3'd5, 8'(i), 3'd0, 8'h00, 1'b0, "stats");
      checkOutput("stats:gcnt0", grant_cnt[1:0], gExp[i]);
    end
`endif

    checkOutput("queue_drained", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/regbank_write_arbiter.md
Name: regbank_write_arbiter

Overview:
- Shares the single write port (we3/wa3/wd3) of the 8x8 register bank among N_REQ requesters using round-robin arbitration with a valid/ready handshake.
- Contains a clear sequencer that writes zero to registers 1..(2**AW-1) on command.
- Guards register 0: the bank maps wa3=0 onto register 1, so this block never drives we3 with wa3=0.
- Sits directly in front of the bank's write port. Read ports are untouched.

Parameters:
- N_REQ, 2, number of write requesters (2..8)
- AW, 3, register address width
- DW, 8, register data width
- CNT_W, 16, grant counter width (used only with the optional feature)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- req_valid  in  N_REQ  per-requester write request
- req_ready  out  N_REQ  per-requester accept; combinational, one-hot or zero
- req_addr  in  N_REQ*AW  packed addresses; requester i uses slice [i*AW +: AW]
- req_data  in  N_REQ*DW  packed data; requester i uses slice [i*DW +: DW]
- clr_start  in  1  request a clear sequence
- clr_busy  out  1  clear sequence in progress
- clr_done  out  1  one-cycle pulse when the clear sequence completes
- x0_drop  out  1  one-cycle pulse: an accepted write to address 0 was discarded
- we3  out  1  bank write enable, registered
- wa3  out  AW  bank write address, registered
- wd3  out  DW  bank write data, registered

Behaviour:
- Reset values (asynchronous, while rst=1): we3=0, wa3=0, wd3=0, clr_busy=0, clr_done=0, x0_drop=0, state=ARB, rr_ptr=N_REQ-1 so requester 0 has first priority, clear counter=1.
- States: ARB, CLEAR, DONE.
- ARB, arbitration:
  - Search starts at (rr_ptr+1) mod N_REQ and proceeds upward with wrap; the first requester with valid=1 wins.
  - req_ready is asserted only for the winner, and only when clr_start=0.
  - A transfer occurs when valid&ready. On transfer, rr_ptr <= winner.
  - With no transfer, rr_ptr holds.
- ARB, write issue:
  - Transfer with addr!=0: next cycle we3=1, wa3=addr, wd3=data (latency 1).
  - Transfer with addr==0: next cycle we3=0 and x0_drop=1. The requester still sees a completed handshake.
  - No transfer: next cycle we3=0. wa3/wd3 hold their last values.
- ARB to CLEAR:
  - clr_start=1 in ARB → no req_ready that cycle; next state CLEAR.
  - clr_start has priority over all requesters.
- CLEAR:
  - clr_busy=1 and all req_ready=0.
  - Each cycle the registered outputs carry we3=1, wa3=cnt, wd3=0, then cnt increments.
  - Writes appear on the port in the cycles following entry: address 1 first, 2**AW-1 last, so 7 writes for AW=3.
  - After the write to 2**AW-1 is registered, next state is DONE.
  - clr_start is ignored while in CLEAR.
- DONE:
  - Lasts one cycle: clr_done=1, clr_busy=0, we3=0, req_ready all 0.
  - cnt reloads to 1; next state ARB.
  - clr_start sampled in DONE is ignored and must be re-asserted in ARB.
- A requester may drop valid without a transfer; no state is kept for it.
- Requester inputs are sampled only in the cycle of transfer; the block has no skid buffering.
- Reset mid-clear: immediate return to ARB with reset values. The partial clear is abandoned and clr_done is never pulsed.
- N_REQ=1: the arbiter degenerates to pass-through with rr_ptr constant.

Optional Feature:
- Macro REGARB_STATS_EN.
- Defined:
  - Adds output grant_cnt, width N_REQ*CNT_W.
  - One counter per requester, incremented on each transfer of that requester, including x0 drops.
  - Counters saturate at all-ones and reset to 0 on rst.
  - Clear sequences do not affect them.
- Undefined: the port and counters do not exist. All other behaviour is identical.

Decomposition:
- Package regbank_arb_pkg holds:
  - state enum arb_state_e {ARB, CLEAR, DONE}
  - default width constants AW_DEF=3, DW_DEF=8
  - localparam function for NREGS=2**AW
- Sub-module rr_arbiter: purely combinational round-robin pick.
  - Inputs: valid vector, rr_ptr.
  - Outputs: one-hot grant, winner index, any_valid.
  - Pointer register stays in the top level.

Test Plan:
- Reset, then req0 valid with addr=3, data=0xA5 → req_ready[0]=1 that cycle; next cycle we3=1, wa3=3, wd3=0xA5.
- req0 and req1 held valid continuously with distinct data → grants alternate 0,1,0,1 over 4 cycles. Port shows the corresponding data in order, 1-cycle lag.
- req1 write to addr=0, data=0xFF → handshake completes; next cycle we3=0, x0_drop=1; register 1 unchanged after readback via the bank.
- clr_start asserted together with req0 valid → req_ready=0; 7 consecutive writes wa3=1..7 with wd3=0; clr_busy high for those cycles, then clr_done pulse; req0 granted in the following ARB cycle.
- rst asserted after the third clear write → outputs return to 0 immediately; state is ARB and no clr_done occurs. A fresh clr_start then completes all 7 writes.
- With REGARB_STATS_EN and CNT_W=2: 5 grants to req0 → grant_cnt[0] reads 1,2,3,3,3.
